fft_sample_buffer: RTL

Ping-pong, parametrised register array that collects a serial stream of FFT input samples into one of two banks of N words and presents a full bank as a flattened parallel bus to the butterfly stage. Optional bit-reversed write addressing delivers samples in the order a decimation-in-time stage expects. While the FFT consumes one bank, the other bank keeps filling. A valid/ready input handshake and a valid/ack output handshake replace the bare write-enable array of the previous generation.

---
 rtl/fft_sample_buffer_if.sv | 34 +++
 rtl/fft_sample_buffer.sv | 138 +++++++++++++
 2 files changed

// File: rtl/fft_sample_buffer_if.sv
// Stream-in / frame-out bundle for fft_sample_buffer.
// The master side feeds samples and acks frames; the slave side is the buffer.
interface fft_sample_buffer_if #(
  parameter int unsigned N   = 32,
  parameter int unsigned MSB = 16
);
  logic             in_valid;
  logic [MSB-1:0]   in_data;
  logic             in_ready;
  logic             out_valid;
  logic [N*MSB-1:0] out_data;
  logic             out_ack;
  logic [7:0]       frame_cnt;

  modport master (
    output in_valid,
    output in_data,
    output out_ack,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  frame_cnt
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ack,
    output in_ready,
    output out_valid,
    output out_data,
    output frame_cnt
  );
endinterface

// File: rtl/fft_sample_buffer.sv
// Ping-pong sample buffer: fills one bank of N words serially while the other bank is
// presented in parallel to the FFT butterfly stage, with optional bit-reversed addressing.
module fft_sample_buffer #(
  parameter int unsigned N      = 32,
  parameter int unsigned MSB    = 16,
  parameter bit          BITREV = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  fft_sample_buffer_if.slave   bus
);

  localparam int unsigned AW = $clog2(N);
  localparam logic [AW-1:0] LastIdx = AW'(N - 1);

  localparam logic [1:0] StFill    = 2'd0;
  localparam logic [1:0] StPresent = 2'd1;
  localparam logic [1:0] StStall   = 2'd2;

  logic [1:0]      state_q, state_d;
  logic            wbank_q, wbank_d;
  logic [AW-1:0]   wcnt_q, wcnt_d;
  logic [7:0]      frame_cnt_q, frame_cnt_d;
  logic [MSB-1:0]  mem_q [2][N];

  logic             in_ready;
  logic             out_valid;
  logic             accept;
  logic             last;
  logic             ack;
  logic             swap;
  logic             rbank;
  logic [AW-1:0]    wslot;
  logic [N*MSB-1:0] out_data;

  function automatic logic [AW-1:0] bit_reverse(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    for (int i = 0; i < int'(AW); i++) begin
      r[i] = a[AW-1-i];
    end
    return r;
  endfunction

  // Handshake outputs are pure state decodes so no path exists from in_valid/out_ack.
  assign in_ready  = (state_q != StStall);
  assign out_valid = (state_q != StFill);
  assign rbank     = ~wbank_q;

  assign accept = bus.in_valid && in_ready;
  assign last   = accept && (wcnt_q == LastIdx);
  assign ack    = bus.out_ack && out_valid;
  assign wslot  = BITREV ? bit_reverse(wcnt_q) : wcnt_q;

  always_comb begin
    state_d     = state_q;
    wbank_d     = wbank_q;
    wcnt_d      = wcnt_q;
    frame_cnt_d = frame_cnt_q;
    swap        = 1'b0;

    if (accept) begin
      wcnt_d = wcnt_q + AW'(1);
    end

    case (state_q)
      StFill: begin
        if (last) begin
          swap    = 1'b1;
          state_d = StPresent;
        end
      end
      StPresent: begin
        // A completed frame replaces the presented one only if it is released this cycle.
        if (last && ack) begin
          swap = 1'b1;
        end else if (last) begin
          state_d = StStall;
        end else if (ack) begin
          state_d = StFill;
        end
      end
      StStall: begin
        if (ack) begin
          swap    = 1'b1;
          state_d = StPresent;
        end
      end
      default: begin
        state_d = StFill;
      end
    endcase

    if (swap) begin
      wbank_d     = ~wbank_q;
      frame_cnt_d = frame_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StFill;
      wbank_q     <= 1'b0;
      wcnt_q      <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wbank_q     <= wbank_d;
      wcnt_q      <= wcnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // The last sample lands in the old write bank on the same edge that makes it the read bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int s = 0; s < int'(N); s++) begin
          mem_q[b][s] <= '0;
        end
      end
    end else if (accept) begin
      mem_q[wbank_q][wslot] <= bus.in_data;
    end
  end

  always_comb begin
    out_data = '0;
    for (int i = 0; i < int'(N); i++) begin
      out_data[i*MSB +: MSB] = mem_q[rbank][i];
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.frame_cnt = frame_cnt_q;

endmodule
